sensor_poll_sequencer: RTL

//  Producer side of the baggage-drop sensor interface. Polls four height sensors in turn over one

---
 rtl/sensor_poll_if.sv | 18 +
 rtl/sensor_poll_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sensor_poll_if.sv
// Shared 4-phase req/ack bus between the poll sequencer (master) and the height sensors (slave).
interface sensor_poll_if;
   logic [1:0] sens_sel;
   logic       sens_req;
   logic       sens_ack;
   logic [7:0] sens_data;
   logic       sens_par;

   modport master (
      output sens_sel, sens_req,
      input  sens_ack, sens_data, sens_par
   );

   modport slave (
      input  sens_sel, sens_req,
      output sens_ack, sens_data, sens_par
   );
endinterface

// File: rtl/sensor_poll_sequencer.sv
// Polls four height sensors over one 4-phase bus and publishes a coherent set of readings.
// Optional build macro SENSOR_PARITY_EN adds an even-parity check on each captured reading.
//
// state  | meaning
// IDLE   | waiting for start_i; outputs hold last set
// REQ    | sens_req high, waiting for ack with timeout
// REL    | sens_req low, waiting for ack release
// COMMIT | copy shadow readings to outputs, raise drop_en
module sensor_poll_sequencer #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   sensor_poll_if.master       bus,
   output logic [7:0]          sensor1_o,
   output logic [7:0]          sensor2_o,
   output logic [7:0]          sensor3_o,
   output logic [7:0]          sensor4_o,
   output logic                drop_en_o,
   output logic                busy_o,
   output logic                err_o
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_REL,
      ST_COMMIT
   } state_t;

   state_t        state_q;
   logic [1:0]    sel_q;
   logic          req_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [7:0]    shadow_q [4];
   logic [7:0]    sensor_q [4];
   logic          drop_en_q;
   logic          busy_q;
   logic          err_q;

   // Saturation is never reached: the round aborts when cnt_d hits TIMEOUT_CYC.
   assign cnt_d = cnt_q + CW'(1);

`ifdef SENSOR_PARITY_EN
   logic par_fail_q;
   logic par_bad;
   assign par_bad = ^{bus.sens_data, bus.sens_par};
`else
   logic par_fail_q;
   logic unused_par;
   assign par_fail_q = 1'b0;
   assign unused_par = bus.sens_par;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         req_q     <= 1'b0;
         cnt_q     <= '0;
         drop_en_q <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            shadow_q[i] <= '0;
            sensor_q[i] <= '0;
         end
`ifdef SENSOR_PARITY_EN
         par_fail_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_q <= ST_REQ;
                  sel_q   <= '0;
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
`ifdef SENSOR_PARITY_EN
                  par_fail_q <= 1'b0;
`endif
               end
            end
            ST_REQ: begin
               if (bus.sens_ack) begin
                  shadow_q[sel_q] <= bus.sens_data;
                  req_q           <= 1'b0;
                  state_q         <= ST_REL;
`ifdef SENSOR_PARITY_EN
                  if (par_bad) begin
                     par_fail_q <= 1'b1;
                     err_q      <= 1'b1;
                     drop_en_q  <= 1'b0;
                  end
`endif
               end else if (cnt_d == CW'(TIMEOUT_CYC)) begin
                  err_q     <= 1'b1;
                  drop_en_q <= 1'b0;
                  req_q     <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_REL: begin
               if (!bus.sens_ack) begin
                  if (par_fail_q) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else if (sel_q == 2'd3) begin
                     state_q <= ST_COMMIT;
                  end else begin
                     sel_q   <= sel_q + 2'd1;
                     cnt_q   <= '0;
                     req_q   <= 1'b1;
                     state_q <= ST_REQ;
                  end
               end
            end
            ST_COMMIT: begin
               for (int i = 0; i < 4; i++) sensor_q[i] <= shadow_q[i];
               drop_en_q <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.sens_sel = sel_q;
   assign bus.sens_req = req_q;
   assign sensor1_o    = sensor_q[0];
   assign sensor2_o    = sensor_q[1];
   assign sensor3_o    = sensor_q[2];
   assign sensor4_o    = sensor_q[3];
   assign drop_en_o    = drop_en_q;
   assign busy_o       = busy_q;
   assign err_o        = err_q;

endmodule
